// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, board baud defaults and
// small elaboration-time helpers used to size counters.
package uart_pkg;

    typedef logic [1:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 2'b00;
    localparam uart_state_t ST_START = 2'b01;
    localparam uart_state_t ST_DATA  = 2'b10;
    localparam uart_state_t ST_STOP  = 2'b11;

    localparam int CLK_FREQ       = 100_000_000;
    localparam int BAUD_RATE      = 19200;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int BAUD_DIV       = CLK_FREQ / (BAUD_RATE * DEF_OVERSAMPLE);

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Never collapse to a zero-width counter for degenerate parameter values.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter paced by an external 16x baud tick; one word per
// accepted start strobe, LSB first, registered line output.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | line high, waiting for i_tx_start
// ST_START | line low for OVERSAMPLE ticks
// ST_DATA  | line = shreg[0], one bit per OVERSAMPLE ticks
// ST_STOP  | line high for SB_TICK ticks, then one done cycle
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SB_TICK    = 16,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_tick,
    input  logic                  i_tx_start,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_tx_done
);

    localparam int TW = cnt_width(max_int(OVERSAMPLE, SB_TICK));
    localparam int BW = cnt_width(DATA_WIDTH);

    localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    uart_state_t           state, state_next;
    logic [TW-1:0]         tick_cnt, tick_next;
    logic [BW-1:0]         bit_cnt, bit_next;
    logic [DATA_WIDTH-1:0] shreg, shreg_next;
    logic                  tx_r, tx_next;
    logic                  done_r, done_next;

    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        bit_next   = bit_cnt;
        shreg_next = shreg;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_tx_start) begin
                    state_next = ST_START;
                    tick_next  = '0;
                    shreg_next = i_data;
                end
            end
            ST_START: begin
                if (i_tick) begin
                    if (tick_cnt == OS_LAST) begin
                        state_next = ST_DATA;
                        tick_next  = '0;
                        bit_next   = '0;
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (i_tick) begin
                    if (tick_cnt == OS_LAST) begin
                        tick_next  = '0;
                        shreg_next = shreg >> 1;
                        if (bit_cnt == BIT_LAST) begin
                            state_next = ST_STOP;
                        end else begin
                            bit_next = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                // Stay in STOP through the done cycle so a strobe there is refused.
                if (done_r) begin
                    state_next = ST_IDLE;
                end else if (i_tick) begin
                    if (tick_cnt == SB_LAST) begin
                        done_next = 1'b1;
                        tick_next = '0;
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        case (state_next)
            ST_START: tx_next = 1'b0;
            ST_DATA:  tx_next = shreg_next[0];
            default:  tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx_r     <= 1'b1;
            done_r   <= 1'b0;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_next;
            bit_cnt  <= bit_next;
            shreg    <= shreg_next;
            tx_r     <= tx_next;
            done_r   <= done_next;
        end
    end

    assign o_tx      = tx_r;
    assign o_busy    = (state != ST_IDLE);
    assign o_tx_done = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (1 and 2 stop bits) on a shared random
// tick stream, a per-cycle tick-counting frame model and mid-bit line capture.
module tb_uart_tx;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_tick = 1'b0;
    logic       i_tx_start = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       tx0, busy0, done0;
    logic       tx1, busy1, done1;
    logic       tick_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx #(.DATA_WIDTH(8), .SB_TICK(16), .OVERSAMPLE(16)) u_dut0 (
        .i_clk(clk), .i_reset(i_reset), .i_tick(i_tick), .i_tx_start(i_tx_start),
        .i_data(i_data), .o_tx(tx0), .o_busy(busy0), .o_tx_done(done0)
    );

    uart_tx #(.DATA_WIDTH(8), .SB_TICK(32), .OVERSAMPLE(16)) u_dut1 (
        .i_clk(clk), .i_reset(i_reset), .i_tick(i_tick), .i_tx_start(i_tx_start),
        .i_data(i_data), .o_tx(tx1), .o_busy(busy1), .o_tx_done(done1)
    );

    always #5 clk = ~clk;

    function automatic int sb_of(input int d);
        return (d == 0) ? 16 : 32;
    endfunction

    function automatic logic dut_tx(input int d);
        return (d == 0) ? tx0 : tx1;
    endfunction

    function automatic logic dut_busy(input int d);
        return (d == 0) ? busy0 : busy1;
    endfunction

    function automatic logic dut_done(input int d);
        return (d == 0) ? done0 : done1;
    endfunction

    // Line in time order, first bit at [9]: start, data LSB first, stop.
    function automatic logic [9:0] build_line(input logic [7:0] d);
        logic [9:0] l;
        l[9] = 1'b0;
        for (int i = 0; i < 8; i++) l[8-i] = d[i];
        l[0] = 1'b1;
        return l;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Shared baud tick stream with random spacing; the checks count ticks, not clocks.
    initial begin : tick_gen
        int gap;
        gap = 0;
        forever begin
            @(negedge clk);
            if (tick_en && gap == 0) begin
                i_tick = 1'b1;
                gap = $urandom_range(0, 3);
            end else begin
                i_tick = 1'b0;
                if (gap > 0) gap--;
            end
        end
    end

    // Reference: a frame is just a tick count since acceptance.
    initial begin : model
        int         n [2];
        logic       act [2];
        logic       hold [2];
        logic [7:0] word [2];
        logic       e_tx;
        for (int d = 0; d < 2; d++) begin
            n[d] = 0; act[d] = 1'b0; hold[d] = 1'b0; word[d] = 8'h00;
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                if (i_reset) begin
                    act[d] = 1'b0; hold[d] = 1'b0;
                end else if (hold[d]) begin
                    hold[d] = 1'b0; act[d] = 1'b0;
                end else if (!act[d]) begin
                    if (i_tx_start) begin
                        act[d] = 1'b1; n[d] = 0; word[d] = i_data;
                    end
                end else if (i_tick) begin
                    n[d]++;
                    if (n[d] == OS * 9 + sb_of(d)) hold[d] = 1'b1;
                end
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                if (!act[d] || n[d] >= OS * 9) e_tx = 1'b1;
                else if (n[d] < OS)            e_tx = 1'b0;
                else                           e_tx = word[d][n[d] / OS - 1];
                check($sformatf("model_tx%0d", d),   {31'd0, dut_tx(d)},   {31'd0, e_tx});
                check($sformatf("model_busy%0d", d), {31'd0, dut_busy(d)}, {31'd0, act[d]});
                check($sformatf("model_done%0d", d), {31'd0, dut_done(d)}, {31'd0, hold[d]});
            end
        end
    end

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while ((busy0 || busy1) && cyc < 8000) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (busy0 || busy1) check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    // Called with i_tx_start already high; the next edge is the accept edge.
    // act 1: extra strobe of 8'h55 40 clocks in.  act 2: ticks frozen for
    // 2000 clocks at tick 70.
    task automatic capture(input int d, input int act, input logic [9:0] exp_line,
                           output logic [9:0] line, output int done_at);
        int   ticks, cyc, frz_bad;
        logic t, seen, e;
        ticks = 0; cyc = 0; seen = 1'b0; line = '1; done_at = -1;
        @(posedge clk);
        @(negedge clk);
        i_tx_start = 1'b0;
        while (!seen && cyc < 8000) begin
            @(posedge clk);
            t = i_tick;
            cyc++;
            if (t) ticks++;
            #1;
            if (act == 1 && cyc == 40) begin i_tx_start = 1'b1; i_data = 8'h55; end
            if (act == 1 && cyc == 41) i_tx_start = 1'b0;
            if (t && ticks % OS == OS / 2 && ticks / OS < 10) line[9 - ticks / OS] = dut_tx(d);
            if (dut_done(d)) begin seen = 1'b1; done_at = ticks; end
            if (act == 2 && t && ticks == 70) begin
                tick_en = 1'b0;
                frz_bad = 0;
                e = exp_line[9 - ticks / OS];
                repeat (2000) begin
                    @(posedge clk); #1;
                    cyc++;
                    if (dut_tx(d) !== e || dut_busy(d) !== 1'b1 || dut_done(d) !== 1'b0) frz_bad++;
                end
                check("freeze_hold", frz_bad, 0);
                tick_en = 1'b1;
            end
        end
        if (!seen) check("capture_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_frame(input logic [7:0] data, input int d, input int act,
                             input logic [9:0] exp_line, input int exp_done, input string tag);
        logic [9:0] line;
        int         done_at;
        wait_idle();
        @(negedge clk);
        i_tx_start = 1'b1;
        i_data = data;
        capture(d, act, exp_line, line, done_at);
        check({tag, "_line"}, {22'd0, line}, {22'd0, exp_line});
        check({tag, "_done_tick"}, done_at, exp_done);
    endtask

    typedef struct {
        logic [7:0] data;
        int         dut;
        int         act;
        logic [9:0] line;
        int         done_at;
    } vec_t;

    vec_t vecs [6];

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int         cnt, bad, ticks, cyc, d;
        logic [7:0] r;
        logic [9:0] line;
        int         done_at;

        vecs[0] = '{data: 8'h14, dut: 0, act: 0, line: 10'b0001010001, done_at: 160};
        vecs[1] = '{data: 8'h81, dut: 1, act: 0, line: 10'b0100000011, done_at: 176};
        vecs[2] = '{data: 8'h5A, dut: 0, act: 2, line: 10'b0010110101, done_at: 160};
        vecs[3] = '{data: 8'hFF, dut: 1, act: 0, line: 10'b0111111111, done_at: 176};
        vecs[4] = '{data: 8'h00, dut: 0, act: 0, line: 10'b0000000001, done_at: 160};
        vecs[5] = '{data: 8'h0A, dut: 1, act: 2, line: 10'b0010100001, done_at: 176};

        repeat (3) @(posedge clk);
        #1;
        check("reset_tx",   {31'd0, tx0},   32'd1);
        check("reset_busy", {31'd0, busy0}, 32'd0);
        check("reset_done", {31'd0, done0}, 32'd0);
        @(negedge clk);
        i_reset = 1'b0;
        tick_en = 1'b1;
        cnt = 0; bad = 0;
        repeat (1000) begin
            @(posedge clk); #1;
            if (done0 || done1) cnt++;
            if (tx0 !== 1'b1 || busy0 !== 1'b0 || tx1 !== 1'b1 || busy1 !== 1'b0) bad++;
        end
        check("idle_done_pulses", cnt, 0);
        check("idle_line", bad, 0);

        for (int i = 0; i < 6; i++)
            run_frame(vecs[i].data, vecs[i].dut, vecs[i].act, vecs[i].line, vecs[i].done_at,
                      $sformatf("vec%0d", i));

        // Second strobe mid-frame ignored, then back-to-back frame.
        run_frame(8'hAA, 0, 1, 10'b0010101011, 160, "aa_with_ignored_55");
        @(negedge clk);
        i_tx_start = 1'b1;
        i_data = 8'h0A;
        @(posedge clk); #1;
        check("strobe_in_done_cycle_ignored", {31'd0, busy0}, 32'd0);
        check("line_high_after_done", {31'd0, tx0}, 32'd1);
        capture(0, 0, 10'b0010100001, line, done_at);
        check("b2b_0a_line", {22'd0, line}, {22'd0, 10'b0010100001});
        check("b2b_0a_done_tick", done_at, 160);

        // Reset in the third data bit aborts the frame; reset beats a start strobe.
        wait_idle();
        @(negedge clk);
        i_tx_start = 1'b1;
        i_data = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        i_tx_start = 1'b0;
        ticks = 0; cyc = 0;
        while (ticks < 56 && cyc < 4000) begin
            @(posedge clk);
            if (i_tick) ticks++;
            cyc++;
        end
        check("abort_reached_bit", ticks, 56);
        #1;
        i_reset = 1'b1;
        i_tx_start = 1'b1;
        @(posedge clk); #1;
        check("abort_tx_high",  {31'd0, tx0},   32'd1);
        check("abort_busy_low", {31'd0, busy0}, 32'd0);
        check("abort_busy1_low", {31'd0, busy1}, 32'd0);
        i_reset = 1'b0;
        i_tx_start = 1'b0;
        cnt = 0;
        repeat (600) begin
            @(posedge clk); #1;
            if (done0 || done1) cnt++;
        end
        check("abort_no_done", cnt, 0);
        run_frame(8'h00, 0, 0, 10'b0000000001, 160, "after_abort_00");

        for (int i = 0; i < 20; i++) begin
            r = 8'($urandom);
            d = $urandom_range(0, 1);
            run_frame(r, d, 0, build_line(r), OS * 9 + sb_of(d), $sformatf("rand%0d", i));
        end

        wait_idle();
        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
